store_unit_32b: RTL and testbench

Execute/memory-side store unit for the 32-bit RISC-V core; it consumes the S-type sign-extended immediate together with rs1/rs2 values and funct3. It computes the effective address, checks alignment and funct3, and drives one word-aligned, byte-strobed write on the data-memory bus under a req/ack handshake with a timeout. It reports completion or a fault back to the pipeline control.

---
 rtl/store_unit_32b_pkg.sv | 24 ++
 rtl/store_lane_align.sv | 40 ++++
 rtl/store_unit_32b.sv | 127 ++++++++++++
 tb/tb_store_unit_32b.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/store_unit_32b_pkg.sv
// Shared encodings for the store unit: funct3 store codes, fault causes and FSM states.
// The lane-align helper imports this package so a future load unit can reuse the same codes.
package store_unit_32b_pkg;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } funct3_e;

  typedef enum logic [1:0] {
    CAUSE_NONE      = 2'b00,
    CAUSE_MISALIGN  = 2'b01,
    CAUSE_ILLEGAL   = 2'b10,
    CAUSE_TIMEOUT   = 2'b11
  } fault_cause_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/store_lane_align.sv
// Combinational byte-lane formation for a store: replicates data across lanes, builds
// the byte strobe and flags illegal funct3 / misaligned access.
module store_lane_align
  import store_unit_32b_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_ea_lo,
  input  logic [31:0] i_data,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic        o_misaligned,
  output logic        o_illegal
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    o_wdata      = '0;
    o_wstrb      = '0;
    o_misaligned = 1'b0;
    o_illegal    = 1'b0;
    case (i_funct3)
      F3_SB: begin
        o_wdata = {4{i_data[7:0]}};
        o_wstrb = 4'b0001 << i_ea_lo;
      end
      F3_SH: begin
        o_wdata      = {2{i_data[15:0]}};
        o_wstrb      = 4'b0011 << i_ea_lo;
        o_misaligned = i_ea_lo[0];
      end
      F3_SW: begin
        o_wdata      = i_data;
        o_wstrb      = 4'b1111;
        o_misaligned = |i_ea_lo;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_unit_32b.sv
// Store unit: computes the effective address, checks funct3/alignment and performs one
// byte-strobed write under a req/ack handshake with a bounded wait, then pulses done or fault.
module store_unit_32b
  import store_unit_32b_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_base,
  input  logic [31:0] in_data,
  input  logic [31:0] in_imm,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  output logic        done,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_addr
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_mem_addr;
  logic [31:0]      r_mem_wdata;
  logic [3:0]       r_mem_wstrb;
  logic             r_done;
  logic             r_fault;
  fault_cause_e     r_fault_cause;
  logic [31:0]      r_fault_addr;

  logic [31:0] w_ea;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic        w_misaligned;
  logic        w_illegal;

  assign w_ea = in_base + in_imm;

  store_lane_align u_lane_align (
    .i_funct3     (in_funct3),
    .i_ea_lo      (w_ea[1:0]),
    .i_data       (in_data),
    .o_wdata      (w_wdata),
    .o_wstrb      (w_wstrb),
    .o_misaligned (w_misaligned),
    .o_illegal    (w_illegal)
  );

  // Request and ready decode straight from the state register, so reset drops mem_req at once.
  assign in_ready    = (r_state == S_IDLE);
  assign mem_req     = (r_state == S_REQ);
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign mem_wstrb   = r_mem_wstrb;
  assign done        = r_done;
  assign fault       = r_fault;
  assign fault_cause = r_fault_cause;
  assign fault_addr  = r_fault_addr;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_mem_wstrb   <= '0;
      r_done        <= 1'b0;
      r_fault       <= 1'b0;
      r_fault_cause <= CAUSE_NONE;
      r_fault_addr  <= '0;
    end else begin
      r_done  <= 1'b0;
      r_fault <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_fault_addr <= w_ea;
            r_cnt        <= '0;
            if (w_illegal) begin
              r_state       <= S_RESP;
              r_fault       <= 1'b1;
              r_fault_cause <= CAUSE_ILLEGAL;
            end else if (w_misaligned) begin
              r_state       <= S_RESP;
              r_fault       <= 1'b1;
              r_fault_cause <= CAUSE_MISALIGN;
            end else begin
              r_mem_addr  <= {w_ea[31:2], 2'b00};
              r_mem_wdata <= w_wdata;
              r_mem_wstrb <= w_wstrb;
              r_state     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          // Ack takes priority over expiry on the same cycle.
          if (mem_ack) begin
            r_state <= S_RESP;
            r_done  <= 1'b1;
          end else if (r_cnt == CNT_LAST) begin
            r_state       <= S_RESP;
            r_fault       <= 1'b1;
            r_fault_cause <= CAUSE_TIMEOUT;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RESP: begin
          r_state       <= S_IDLE;
          r_fault_cause <= CAUSE_NONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_unit_32b.sv
// Directed self-checking bench for store_unit_32b built with TIMEOUT = 4.
module tb_store_unit_32b;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_funct3;
  logic [31:0] in_base;
  logic [31:0] in_data;
  logic [31:0] in_imm;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic        done;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] fault_addr;

  int n_cmp = 0;
  int n_bad = 0;

  store_unit_32b #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_funct3   (in_funct3),
    .in_base     (in_base),
    .in_data     (in_data),
    .in_imm      (in_imm),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_ack     (mem_ack),
    .done        (done),
    .fault       (fault),
    .fault_cause (fault_cause),
    .fault_addr  (fault_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic accept(input logic [2:0] f3, input logic [31:0] b, input logic [31:0] imm,
                        input logic [31:0] d);
    in_valid  = 1'b1;
    in_funct3 = f3;
    in_base   = b;
    in_imm    = imm;
    in_data   = d;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_funct3 = 3'b111;
    in_base   = 32'h5A5A_5A5A;
    in_imm    = 32'h1234_5677;
    in_data   = 32'h0;
  endtask

  // Accept, check the bus fields in the first REQ cycle, ack there, check done then ready.
  task automatic run_store(input string nm, input logic [2:0] f3, input logic [31:0] b,
                           input logic [31:0] imm, input logic [31:0] d,
                           input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                           input logic [3:0] exp_wstrb);
    accept(f3, b, imm, d);
    n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL %s_req: got %b want 1", nm, mem_req); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL %s_busy: got %b want 0", nm, in_ready); end
    n_cmp++; if (mem_addr !== exp_addr) begin n_bad++; $display("FAIL %s_addr: got %h want %h", nm, mem_addr, exp_addr); end
    n_cmp++; if (mem_wdata !== exp_wdata) begin n_bad++; $display("FAIL %s_wdata: got %h want %h", nm, mem_wdata, exp_wdata); end
    n_cmp++; if (mem_wstrb !== exp_wstrb) begin n_bad++; $display("FAIL %s_wstrb: got %b want %b", nm, mem_wstrb, exp_wstrb); end
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL %s_done: got %b want 1", nm, done); end
    n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL %s_nofault: got %b want 0", nm, fault); end
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL %s_req_resp: got %b want 0", nm, mem_req); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL %s_resp_busy: got %b want 0", nm, in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL %s_ready: got %b want 1", nm, in_ready); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL %s_done_pulse: got %b want 0", nm, done); end
  endtask

  task automatic check_fault(input string nm, input logic [1:0] exp_cause, input logic [31:0] exp_addr);
    n_cmp++; if (fault !== 1'b1) begin n_bad++; $display("FAIL %s_fault: got %b want 1", nm, fault); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL %s_nodone: got %b want 0", nm, done); end
    n_cmp++; if (fault_cause !== exp_cause) begin n_bad++; $display("FAIL %s_cause: got %b want %b", nm, fault_cause, exp_cause); end
    n_cmp++; if (fault_addr !== exp_addr) begin n_bad++; $display("FAIL %s_faddr: got %h want %h", nm, fault_addr, exp_addr); end
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL %s_noreq: got %b want 0", nm, mem_req); end
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL %s_ready: got %b want 1", nm, in_ready); end
    n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL %s_fault_pulse: got %b want 0", nm, fault); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_funct3 = 3'b0; in_base = '0; in_data = '0; in_imm = '0;
    mem_ack = 1'b0;
    #2;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", in_ready); end
    n_cmp++; if ({mem_req, done, fault} !== 3'b000) begin n_bad++; $display("FAIL rst_pulses: got %b want 000", {mem_req, done, fault}); end
    n_cmp++; if ({mem_addr, mem_wdata} !== 64'h0) begin n_bad++; $display("FAIL rst_bus: got %h want 0", {mem_addr, mem_wdata}); end
    n_cmp++; if ({mem_wstrb, fault_cause, fault_addr} !== 38'h0) begin n_bad++; $display("FAIL rst_misc: got %h want 0", {mem_wstrb, fault_cause, fault_addr}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    // Stray ack while idle must be ignored.
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    n_cmp++; if ({done, fault, mem_req} !== 3'b000) begin n_bad++; $display("FAIL idle_ack: got %b want 000", {done, fault, mem_req}); end
  endtask

  task automatic test_sw();
    run_store("sw", 3'b010, 32'h0000_1000, 32'hFFFF_FFFC, 32'hDEAD_BEEF,
              32'h0000_0FFC, 32'hDEAD_BEEF, 4'b1111);
  endtask

  task automatic test_sb_sh();
    run_store("sb", 3'b000, 32'h0000_2001, 32'h0000_0002, 32'h0000_00A5,
              32'h0000_2000, 32'hA5A5_A5A5, 4'b1000);
    run_store("sh_wrap", 3'b001, 32'hFFFF_FFFF, 32'h0000_0003, 32'h1234_ABCD,
              32'h0000_0000, 32'hABCD_ABCD, 4'b1100);
  endtask

  task automatic test_faults();
    accept(3'b001, 32'h0000_3000, 32'h0000_0003, 32'h0);
    check_fault("sh_mis", 2'b01, 32'h0000_3003);
    accept(3'b011, 32'h0000_4000, 32'h0000_0001, 32'h0);
    check_fault("illegal", 2'b10, 32'h0000_4001);
  endtask

  task automatic test_timeout();
    int n_req = 0;
    accept(3'b010, 32'h0000_5000, 32'h0000_0000, 32'h0BAD_F00D);
    while (mem_req === 1'b1 && n_req < 20) begin
      n_req++;
      @(posedge clk); #1;
    end
    n_cmp++; if (n_req != 4) begin n_bad++; $display("FAIL tmo_req_cycles: got %0d want 4", n_req); end
    check_fault("tmo", 2'b11, 32'h0000_5000);
  endtask

  task automatic test_ack_on_expiry();
    accept(3'b010, 32'h0000_6004, 32'h0000_0000, 32'h1111_2222);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_6004) begin n_bad++; $display("FAIL exp_hold%0d: got %b/%h want 1/00006004", i, mem_req, mem_addr); end
      @(posedge clk); #1;
    end
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    n_cmp++; if ({done, fault, fault_cause} !== 4'b1000) begin n_bad++; $display("FAIL exp_done: got %b want 1000", {done, fault, fault_cause}); end
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL exp_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_reset_mid_req();
    accept(3'b010, 32'h0000_7000, 32'h0000_0008, 32'hCAFE_0001);
    n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL mid_req: got %b want 1", mem_req); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({mem_req, in_ready} !== 2'b01) begin n_bad++; $display("FAIL mid_async: got %b want 01", {mem_req, in_ready}); end
    @(posedge clk); #1;
    n_cmp++; if ({done, fault} !== 2'b00) begin n_bad++; $display("FAIL mid_nopulse: got %b want 00", {done, fault}); end
    rst_n = 1'b1;
    run_store("post_rst", 3'b010, 32'h0000_7000, 32'h0000_0008, 32'hCAFE_0001,
              32'h0000_7008, 32'hCAFE_0001, 4'b1111);
  endtask

  initial begin
    test_reset();
    test_sw();
    test_sb_sh();
    test_faults();
    test_timeout();
    test_ack_on_expiry();
    test_reset_mid_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
